// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared burst, response and FSM state definitions for the AXI memory responder
package axi_pkg;

    localparam int LANES = 4;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    localparam logic RESP_OKAY   = 1'b0;
    localparam logic RESP_SLVERR = 1'b1;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_SEND
    } r_state_e;

endpackage

// File: rtl/axi_addr_gen.sv
// rtl/axi_addr_gen.sv - combinational next-beat address, byte-lane mask and beat legality check
module axi_addr_gen
    import axi_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_DEPTH = 256
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        len,
    input  logic [2:0]        size,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr,
    output logic [LANES-1:0]  lane_mask,
    output logic              beat_err
);

    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] incr_m1;
    logic [ADDR_W-1:0] wrap_mask;
    logic [7:0]        lane_base;
    logic [1:0]        lane_off;
    logic              wrap_len_ok;

    always_comb begin
        incr        = ADDR_W'(1) << size;
        incr_m1     = incr - ADDR_W'(1);
        wrap_mask   = ((ADDR_W'(len) + ADDR_W'(1)) * incr) - ADDR_W'(1);
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);

        // the reserved burst code steps like INCR; it is flagged as an error below
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~wrap_mask) | ((addr + incr) & wrap_mask);
            default:     next_addr = (addr & ~incr_m1) + incr;
        endcase

        case (size)
            3'd0:    lane_base = 8'h01;
            3'd1:    lane_base = 8'h03;
            default: lane_base = 8'h0F;
        endcase
        lane_off  = addr[1:0] & ~incr_m1[1:0];
        lane_mask = LANES'(lane_base << lane_off);

        beat_err = (size > 3'd2)
                || (burst == BURST_RSVD)
                || ((burst == BURST_WRAP) && (!wrap_len_ok || ((addr & incr_m1) != '0)))
                || ((addr >> 2) >= ADDR_W'(MEM_DEPTH));
    end

endmodule

// File: rtl/axi_mem_responder.sv
// rtl/axi_mem_responder.sv - AXI4 memory-backed slave with independent write and read burst FSMs
module axi_mem_responder
    import axi_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] AWADDR,
    input  logic [7:0]        AWLEN,
    input  logic [2:0]        AWSIZE,
    input  logic [1:0]        AWBURST,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [DATA_W-1:0] WDATA,
    input  logic              WVALID,
    input  logic              WLAST,
    output logic              WREADY,
    output logic              BRESP,
    output logic              BVALID,
    input  logic              BREADY,
    input  logic [ADDR_W-1:0] ARADDR,
    input  logic [7:0]        ARLEN,
    input  logic [2:0]        ARSIZE,
    input  logic [1:0]        ARBURST,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [DATA_W-1:0] RDATA,
    output logic              RRESP,
    output logic              RLAST,
    output logic              RVALID,
    input  logic              RREADY
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    logic [DATA_W-1:0] mem_q [MEM_DEPTH];

    w_state_e          w_state_q, w_state_d;
    logic              awready_q, awready_d, wready_q, wready_d;
    logic              bvalid_q, bvalid_d, bresp_q, bresp_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        wlen_q, wlen_d, wbeat_q, wbeat_d;
    logic [2:0]        wsize_q, wsize_d;
    logic [1:0]        wburst_q, wburst_d;
    logic              werr_q, werr_d, wover_q, wover_d;
    logic              mem_we, w_drop, w_mismatch;
    logic [ADDR_W-1:0] w_next;
    logic [LANES-1:0]  w_lanes;
    logic              w_err;

    r_state_e          r_state_q, r_state_d;
    logic              arready_q, arready_d, rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rresp_q, rresp_d, rlast_q, rlast_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d, r_addr_in, r_next;
    logic [7:0]        rlen_q, rlen_d, rbeat_q, rbeat_d, r_len_in;
    logic [2:0]        rsize_q, rsize_d, r_size_in;
    logic [1:0]        rburst_q, rburst_d, r_burst_in;
    logic [LANES-1:0]  r_lanes;
    logic              r_err;

    axi_addr_gen #(.ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH)) u_wgen (
        .addr(waddr_q), .len(wlen_q), .size(wsize_q), .burst(wburst_q),
        .next_addr(w_next), .lane_mask(w_lanes), .beat_err(w_err)
    );

    // in R_IDLE the generator looks at the AR channel so beat 0 loads on the handshake
    assign r_addr_in  = (r_state_q == R_IDLE) ? ARADDR  : raddr_q;
    assign r_len_in   = (r_state_q == R_IDLE) ? ARLEN   : rlen_q;
    assign r_size_in  = (r_state_q == R_IDLE) ? ARSIZE  : rsize_q;
    assign r_burst_in = (r_state_q == R_IDLE) ? ARBURST : rburst_q;

    axi_addr_gen #(.ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH)) u_rgen (
        .addr(r_addr_in), .len(r_len_in), .size(r_size_in), .burst(r_burst_in),
        .next_addr(r_next), .lane_mask(r_lanes), .beat_err(r_err)
    );

    always_comb begin
        w_state_d = w_state_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        waddr_d   = waddr_q;
        wlen_d    = wlen_q;
        wsize_d   = wsize_q;
        wburst_d  = wburst_q;
        wbeat_d   = wbeat_q;
        werr_d    = werr_q;
        wover_d   = wover_q;
        mem_we    = 1'b0;
        w_drop    = w_err || wover_q;
        w_mismatch = !wover_q && (WLAST != (wbeat_q == wlen_q));
        case (w_state_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (AWVALID && awready_q) begin
                    waddr_d   = AWADDR;
                    wlen_d    = AWLEN;
                    wsize_d   = AWSIZE;
                    wburst_d  = AWBURST;
                    wbeat_d   = 8'd0;
                    werr_d    = 1'b0;
                    wover_d   = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (WVALID && wready_q) begin
                    mem_we  = !w_drop && !reset;
                    waddr_d = w_next;
                    wbeat_d = wbeat_q + 8'd1;
                    werr_d  = werr_q || w_drop || w_mismatch;
                    if (!WLAST && (wbeat_q == wlen_q)) begin
                        wover_d = 1'b1;
                    end
                    if (WLAST) begin
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bresp_d   = werr_d;
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (BREADY && bvalid_q) begin
                    bvalid_d  = 1'b0;
                    bresp_d   = RESP_OKAY;
                    awready_d = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rsize_d   = rsize_q;
        rburst_d  = rburst_q;
        rbeat_d   = rbeat_q;
        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ARVALID && arready_q) begin
                    rvalid_d  = 1'b1;
                    rdata_d   = r_err ? '0 : mem_q[r_addr_in[IDX_W+1:2]];
                    rresp_d   = r_err;
                    rlast_d   = (ARLEN == 8'd0);
                    raddr_d   = r_next;
                    rlen_d    = ARLEN;
                    rsize_d   = ARSIZE;
                    rburst_d  = ARBURST;
                    rbeat_d   = 8'd0;
                    arready_d = 1'b0;
                    r_state_d = R_SEND;
                end
            end
            R_SEND: begin
                if (RREADY && rvalid_q) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        arready_d = 1'b1;
                        r_state_d = R_IDLE;
                    end else begin
                        rdata_d = r_err ? '0 : mem_q[r_addr_in[IDX_W+1:2]];
                        rresp_d = r_err;
                        rlast_d = ((rbeat_q + 8'd1) == rlen_q);
                        rbeat_d = rbeat_q + 8'd1;
                        raddr_d = r_next;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 1'b0;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wsize_q   <= '0;
            wburst_q  <= '0;
            wbeat_q   <= '0;
            werr_q    <= 1'b0;
            wover_q   <= 1'b0;
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 1'b0;
            rlast_q   <= 1'b0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rsize_q   <= '0;
            rburst_q  <= '0;
            rbeat_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wsize_q   <= wsize_d;
            wburst_q  <= wburst_d;
            wbeat_q   <= wbeat_d;
            werr_q    <= werr_d;
            wover_q   <= wover_d;
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rsize_q   <= rsize_d;
            rburst_q  <= rburst_d;
            rbeat_q   <= rbeat_d;
        end
    end

    // memory is never cleared; reads above sample it before this edge's write lands
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < LANES; i++) begin
                if (w_lanes[i]) begin
                    mem_q[waddr_q[IDX_W+1:2]][8*i +: 8] <= WDATA[8*i +: 8];
                end
            end
        end
    end

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;
    assign RLAST   = rlast_q;

endmodule

// File: tb/tb_axi_mem_responder.sv
// tb/tb_axi_mem_responder.sv - scoreboard bench for axi_mem_responder against a byte-level memory model
module tb_axi_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] AWADDR = '0, ARADDR = '0, WDATA = '0;
    logic [7:0]  AWLEN = '0, ARLEN = '0;
    logic [2:0]  AWSIZE = '0, ARSIZE = '0;
    logic [1:0]  AWBURST = '0, ARBURST = '0;
    logic        AWVALID = 1'b0, WVALID = 1'b0, WLAST = 1'b0, BREADY = 1'b0;
    logic        ARVALID = 1'b0, RREADY = 1'b0;
    logic        AWREADY, WREADY, BRESP, BVALID, ARREADY, RRESP, RLAST, RVALID;
    logic [31:0] RDATA;

    always #5 clk = ~clk;

    axi_mem_responder #(.ADDR_W(32), .DATA_W(32), .MEM_DEPTH(256)) dut (
        .clk(clk), .reset(reset),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WVALID(WVALID), .WLAST(WLAST), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        resp;
        logic        last;
    } rexp_t;

    logic [31:0] model_mem [256];
    rexp_t       exp_r[$];
    logic        exp_b[$];
    logic [31:0] wdata_src[$];
    int          vectors = 0;
    int          miscompares = 0;
    bit          rand_ready = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: event missing within cycle budget", name);
    endtask

    // address of beat i, from the burst rules directly rather than by iterating
    function automatic logic [31:0] beat_addr(input logic [31:0] a, input int len, input int size,
                                              input int burst, input int i);
        logic [31:0] incr, wb, base;
        incr = 32'd1 << size;
        if (burst == 0) return a;
        if (burst == 2) begin
            wb   = (len + 1) * incr;
            base = a - (a % wb);
            return base + ((a - base + i * incr) % wb);
        end
        if (i == 0) return a;
        return (a - (a % incr)) + i * incr;
    endfunction

    function automatic bit beat_bad(input logic [31:0] a, input int len, input int size, input int burst);
        if (size > 2 || burst == 3) return 1'b1;
        if (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b1;
        if (burst == 2 && (a % (32'd1 << size)) != 0) return 1'b1;
        return (a >> 2) >= 256;
    endfunction

    function automatic logic sig_of(input int which);
        case (which)
            0:       return AWREADY;
            1:       return WREADY;
            default: return ARREADY;
        endcase
    endfunction

    task automatic wait_ready(input int which, input string name);
        int n = 0;
        @(negedge clk);
        while (!sig_of(which) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) fail_now(name);
    endtask

    task automatic drive_aw(input logic [31:0] a, input int len, input int size, input int burst);
        @(posedge clk); #1;
        AWADDR = a; AWLEN = 8'(len); AWSIZE = 3'(size); AWBURST = 2'(burst); AWVALID = 1'b1;
        wait_ready(0, "awready_wait");
        @(posedge clk); #1;
        AWVALID = 1'b0;
    endtask

    task automatic drive_w(input logic [31:0] d, input bit last);
        if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
        end
        WDATA = d; WLAST = last; WVALID = 1'b1;
        wait_ready(1, "wready_wait");
        @(posedge clk); #1;
        WVALID = 1'b0; WLAST = 1'b0;
    endtask

    task automatic model_write(input logic [31:0] a, input int size, input logic [31:0] d);
        int off;
        off = int'(a % 4) & ~((1 << size) - 1);
        for (int b = 0; b < 4; b++)
            if (b >= off && b < off + (1 << size))
                model_mem[a >> 2][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic do_write(input logic [31:0] a, input int len, input int size, input int burst, input int nbeats);
        logic [31:0] d [$];
        logic [31:0] ba;
        bit          bad = (nbeats != len + 1);
        for (int i = 0; i < nbeats; i++) begin
            d.push_back(wdata_src.size() != 0 ? wdata_src.pop_front() : $urandom);
            ba = beat_addr(a, len, size, burst, i);
            if (i > len || beat_bad(ba, len, size, burst)) bad = 1'b1;
            else model_write(ba, size, d[i]);
        end
        exp_b.push_back(bad);
        drive_aw(a, len, size, burst);
        for (int i = 0; i < nbeats; i++) drive_w(d[i], i == nbeats - 1);
        for (int n = 0; n < 200 && exp_b.size() != 0; n++) @(negedge clk);
        if (exp_b.size() != 0) begin
            fail_now("bresp_drain");
            exp_b.delete();
        end
    endtask

    task automatic issue_ar(input logic [31:0] a, input int len, input int size, input int burst);
        @(posedge clk); #1;
        ARADDR = a; ARLEN = 8'(len); ARSIZE = 3'(size); ARBURST = 2'(burst); ARVALID = 1'b1;
        wait_ready(2, "arready_wait");
        @(posedge clk); #1;
        ARVALID = 1'b0;
        for (int n = 0; n < 400 && exp_r.size() != 0; n++) @(negedge clk);
        if (exp_r.size() != 0) begin
            fail_now("rdata_drain");
            exp_r.delete();
        end
    endtask

    task automatic do_read(input logic [31:0] a, input int len, input int size, input int burst);
        logic [31:0] ba;
        bit          bad;
        for (int i = 0; i <= len; i++) begin
            ba  = beat_addr(a, len, size, burst, i);
            bad = beat_bad(ba, len, size, burst);
            exp_r.push_back('{data: bad ? 32'h0 : model_mem[ba >> 2], resp: bad, last: (i == len)});
        end
        issue_ar(a, len, size, burst);
    endtask

    initial forever begin
        @(posedge clk); #1;
        if (rand_ready) begin
            BREADY = ($urandom_range(0, 3) != 0);
            RREADY = ($urandom_range(0, 3) != 0);
        end
    end

    logic        stalled = 1'b0;
    logic [31:0] held_data;
    logic        held_resp, held_last;

    initial forever begin
        @(negedge clk);
        if (!reset) begin
            if (BVALID && BREADY) begin
                if (exp_b.size() == 0) fail_now("unexpected_bvalid");
                else check("bresp", 32'(BRESP), 32'(exp_b.pop_front()));
            end
            if (stalled && RVALID) begin
                check("rdata_stable", RDATA, held_data);
                check("rlast_stable", 32'(RLAST), 32'(held_last));
                check("rresp_stable", 32'(RRESP), 32'(held_resp));
            end
            if (RVALID && RREADY) begin
                if (exp_r.size() == 0) fail_now("unexpected_rvalid");
                else begin
                    rexp_t e;
                    e = exp_r.pop_front();
                    check("rdata", RDATA, e.data);
                    check("rresp", 32'(RRESP), 32'(e.resp));
                    check("rlast", 32'(RLAST), 32'(e.last));
                end
            end
            stalled   = RVALID && !RREADY;
            held_data = RDATA;
            held_resp = RRESP;
            held_last = RLAST;
        end
    end

    initial begin
        int len, size, burst, nb;
        logic [31:0] a;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_awready", 32'(AWREADY), 0);
        check("rst_wready", 32'(WREADY), 0);
        check("rst_bvalid", 32'(BVALID), 0);
        check("rst_bresp", 32'(BRESP), 0);
        check("rst_arready", 32'(ARREADY), 0);
        check("rst_rvalid", 32'(RVALID), 0);
        check("rst_rdata", RDATA, 0);
        check("rst_rlast", 32'(RLAST), 0);
        check("rst_rresp", 32'(RRESP), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_awready", 32'(AWREADY), 1);
        check("post_rst_arready", 32'(ARREADY), 1);

        for (int w = 0; w < 16; w++) do_write(32'(w * 64), 15, 2, 1, 16);

        wdata_src = '{32'hA0A0_0000, 32'hA1A1_1111, 32'hA2A2_2222, 32'hA3A3_3333};
        do_write(32'h10, 3, 2, 1, 4);
        exp_r.push_back('{data: 32'hA0A0_0000, resp: 1'b0, last: 1'b0});
        exp_r.push_back('{data: 32'hA1A1_1111, resp: 1'b0, last: 1'b0});
        exp_r.push_back('{data: 32'hA2A2_2222, resp: 1'b0, last: 1'b0});
        exp_r.push_back('{data: 32'hA3A3_3333, resp: 1'b0, last: 1'b1});
        issue_ar(32'h10, 3, 2, 1);

        do_read(32'h38, 3, 2, 2);
        do_read(32'h38, 2, 2, 2);

        wdata_src = '{32'h1122_3344};
        do_write(32'h20, 0, 2, 1, 1);
        wdata_src = '{32'h0000_AB00};
        do_write(32'h21, 0, 0, 1, 1);
        exp_r.push_back('{data: 32'h1122_AB44, resp: 1'b0, last: 1'b1});
        issue_ar(32'h20, 0, 2, 1);

        exp_r.push_back('{data: 32'h0, resp: 1'b1, last: 1'b1});
        issue_ar(32'h400, 0, 2, 1);
        do_write(32'h400, 0, 2, 1, 1);
        do_read(32'h0, 0, 2, 1);

        rand_ready = 1'b0;
        @(posedge clk); #1;
        RREADY = 1'b1;
        fork
            do_read(32'h40, 7, 2, 1);
            begin
                for (int k = 0; k < 50 && !RVALID; k++) @(negedge clk);
                @(posedge clk);
                @(posedge clk); #1;
                RREADY = 1'b0;
                repeat (3) @(posedge clk);
                #1 RREADY = 1'b1;
            end
        join
        rand_ready = 1'b1;

        do_write(32'h80, 3, 2, 1, 2);
        do_read(32'h80, 3, 2, 1);
        do_write(32'hC0, 1, 2, 1, 4);
        do_read(32'hC0, 3, 2, 1);

        for (int t = 0; t < 60; t++) begin
            size  = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
            burst = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
            if (burst == 2 && $urandom_range(0, 4) != 0) len = (2 << $urandom_range(0, 3)) - 1;
            else len = $urandom_range(0, 7);
            a = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(1024, 2047)) : 32'($urandom_range(0, 1023));
            if (burst == 2 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << size) - 1);
            if ($urandom_range(0, 1) == 0) begin
                nb = len + 1;
                if ($urandom_range(0, 7) == 0) nb = len + 2;
                else if ($urandom_range(0, 7) == 0 && len > 0) nb = len;
                do_write(a, len, size, burst, nb);
            end else begin
                do_read(a, len, size, burst);
            end
        end

        rand_ready = 1'b0;
        BREADY = 1'b1;
        drive_aw(32'h100, 3, 2, 1);
        drive_w(32'hDEAD_0001, 1'b0);
        drive_w(32'hDEAD_0002, 1'b0);
        model_mem[32'h100 >> 2] = 32'hDEAD_0001;
        model_mem[32'h104 >> 2] = 32'hDEAD_0002;
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("rst_mid_bvalid", 32'(BVALID), 0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_awready", 32'(AWREADY), 1);
        repeat (4) begin
            @(negedge clk);
            check("rst_mid_no_b", 32'(BVALID), 0);
        end
        rand_ready = 1'b1;
        do_read(32'h100, 1, 2, 1);

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axi_mem_responder.md
Name: axi_mem_responder

Overview:
- AXI4 memory-backed responder: the slave-side endpoint that terminates the write and read channels driven by axi_master.
- Holds a word-addressed register array. Supports FIXED/INCR/WRAP bursts, narrow transfers and per-beat error responses.
- Write and read paths are independent FSMs, each with at most one outstanding burst.
- Used as a drop-in memory model and synthesizable scratchpad behind the master.

Parameters:
- ADDR_W, 32, address width of AWADDR/ARADDR
- DATA_W, 32, data width; fixed at 32 in this revision (4 byte lanes)
- MEM_DEPTH, 256, number of 32-bit words; word index = addr[ADDR_W-1:2]

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high reset
- AWADDR in 32, AWLEN in 8, AWSIZE in 3, AWBURST in 2, AWVALID in 1, AWREADY out 1: write address channel
- WDATA in 32, WVALID in 1, WLAST in 1, WREADY out 1: write data channel
- BRESP out 1, BVALID out 1, BREADY in 1: write response channel; BRESP 0=OKAY, 1=SLVERR
- ARADDR in 32, ARLEN in 8, ARSIZE in 3, ARBURST in 2, ARVALID in 1, ARREADY out 1: read address channel
- RDATA out 32, RRESP out 1, RLAST out 1, RVALID out 1, RREADY in 1: read data channel

Behaviour:
- Reset:
  - All outputs are registered and reset to 0, including AWREADY and ARREADY.
  - Both FSMs go to IDLE. Memory contents are not cleared.
  - AWREADY and ARREADY rise in the first cycle after reset deasserts.
  - Reset mid-burst abandons the burst: no B or R response is issued, and beats already written stay in memory.
- Write FSM, W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: AWREADY=1. On AW handshake, latch addr/len/size/burst, clear beat counter and error flag; AWREADY=0 and WREADY=1 from the next cycle.
  - W_DATA: each W handshake writes one beat and advances the address via axi_addr_gen.
  - The WLAST handshake ends the burst: WREADY=0 and BVALID=1 on the next cycle.
  - W_RESP: BVALID and BRESP are held until BREADY; AWREADY=1 the cycle after the B handshake.
- Read FSM, R_IDLE -> R_SEND -> R_IDLE:
  - R_IDLE: ARREADY=1. On AR handshake, next cycle: RVALID=1, RDATA=mem[word], RLAST=(len==0), ARREADY=0.
  - On an R handshake of a non-last beat, RDATA/RRESP/RLAST are reloaded for the next address, with RVALID held at 1 (one beat per cycle).
  - On the RLAST handshake: RVALID=0, and ARREADY=1 next cycle.
  - While RVALID=1 and RREADY=0, RDATA, RRESP and RLAST must stay stable.
- Address generation, with incr = 1<<size:
  - FIXED (00): address constant.
  - INCR (01): next = (addr & ~(incr-1)) + incr. An unaligned start is aligned for beats after the first.
  - WRAP (10): wrap_bytes = (len+1)*incr; next = (addr & ~(wrap_bytes-1)) | ((addr+incr) & (wrap_bytes-1)).
  - Arithmetic is ADDR_W bits and wraps modulo 2^ADDR_W.
- Byte lanes for narrow transfers: lanes = ((1<<incr)-1) << (addr[1:0] & ~(incr-1)).
  - Writes update only those lanes, taking data from the same WDATA lanes.
  - Reads always return the full word.
- Error conditions (SLVERR):
  - size > 2.
  - burst == 11; treated as INCR for stepping.
  - WRAP with len not in {1,3,7,15}.
  - WRAP with a start address not aligned to size.
  - Word index >= MEM_DEPTH.
- Error effects:
  - Errored write beats are dropped; BRESP=1 if any beat errored (sticky flag).
  - Errored read beats return RDATA=0 with RRESP=1 for that beat only.
- WLAST mismatch:
  - WLAST earlier than beat len: burst ends there, BRESP=1.
  - Beats past len without WLAST are accepted but dropped, BRESP=1, and the burst ends at WLAST.
- RLAST is asserted exactly on beat len.
- Read/write collision: a read of a word written in the same cycle returns the old data (read-before-write).
- Write and read handshakes may occur in the same cycle with no interaction.

Decomposition:
- Package axi_pkg:
  - burst codes FIXED/INCR/WRAP/RSVD
  - RESP_OKAY/RESP_SLVERR
  - write and read FSM state enums
  - byte-lane width constant
- Sub-module axi_addr_gen (combinational), instantiated once per path:
  - inputs: addr, len, size, burst
  - outputs: next_addr, lane_mask, beat_err (covers size/burst/wrap-legality/range checks)

Test Plan:
- INCR write AWADDR=0x10 len=3 size=2, WDATA A0..A3 -> mem[4..7]=A0..A3, BRESP=0; INCR read of same -> RDATA A0..A3, RLAST on beat 3, RRESP=0.
- WRAP read ARADDR=0x38 len=3 size=2 -> beats from words 0x38,0x3C,0x30,0x34; WRAP with len=2 -> RRESP=1 on all beats.
- Narrow write AWADDR=0x21 size=0 WDATA=0x0000AB00 over mem[8]=0x11223344 -> mem[8]=0x1122AB44, BRESP=0.
- Out of range: ARADDR=0x400, MEM_DEPTH=256, len=0 -> RDATA=0, RRESP=1, RLAST=1; write to 0x400 -> memory unchanged, BRESP=1.
- Backpressure: RREADY low for 3 cycles mid-burst -> RDATA/RLAST stable. Early WLAST on beat 1 of len=3 -> 2 beats written, BRESP=1.
- Reset asserted during W_DATA after 2 beats -> BVALID never rises, AWREADY=1 the cycle after reset release, the 2 written words persist.
